// File: rtl/activation_collector.sv
// Purpose : gathers one frame of output-layer activations into a packed vector
//           and pulses digit_en once every slot has been filled.
// Latency : slot written on the accepting edge; digit_en high the cycle after the last beat.
// Backpressure: act_ready is high only while collecting. It is decoded from the
//           state register, so there is no combinational path from act_valid.
// Macro   : ACT_CLIP_EN selects ReLU + saturation clipping. When the macro is
//           undefined, plain truncation is used.
// Ports   : clk, reset (async active-low), start, act_valid/act_ready/act_index/act_data (beat stream),
//           output_activations (packed slots), digit_en (done pulse), busy, error (sticky).
module activation_collector #(
  parameter int NEURON_NUMBER = 10,
  parameter int RESOLUTION    = 8,
  parameter int ACC_WIDTH     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              act_valid,
  output logic                              act_ready,
  input  logic [3:0]                        act_index,
  input  logic [ACC_WIDTH-1:0]              act_data,
  output logic [RESOLUTION*NEURON_NUMBER-1:0] output_activations,
  output logic                              digit_en,
  output logic                              busy,
  output logic                              error
);

  localparam int CW = $clog2(NEURON_NUMBER + 1);
  localparam logic [4:0] IDX_LIM = 5'(NEURON_NUMBER);
  localparam logic [CW-1:0] LAST_CNT = CW'(NEURON_NUMBER - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                              state_q, state_d;
  logic [NEURON_NUMBER-1:0]            mask_q, mask_d;
  logic [CW-1:0]                       count_q, count_d;
  logic                                error_q, error_d;
  logic [RESOLUTION*NEURON_NUMBER-1:0] slots_q, slots_d;
  logic                                act_ready_q, act_ready_d;
  logic                                digit_en_q, digit_en_d;
  logic                                busy_q, busy_d;

  logic [RESOLUTION-1:0]               clip_val;
  logic [NEURON_NUMBER-1:0]            idx_onehot;
  logic                                in_range;
  logic                                dup;

  // Clip the signed accumulator value into an unsigned slot.
`ifdef ACT_CLIP_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** RESOLUTION) - 1);
  always_comb begin
    if (act_data[ACC_WIDTH-1]) begin
      clip_val = '0;
    end else if (act_data > SAT_MAX) begin
      // Only non-negative values reach this compare, so an unsigned compare is safe.
      clip_val = '1;
    end else begin
      clip_val = act_data[RESOLUTION-1:0];
    end
  end
`else
  logic unused_data_hi;
  assign unused_data_hi = ^act_data[ACC_WIDTH-1:RESOLUTION];
  always_comb begin
    clip_val = act_data[RESOLUTION-1:0];
  end
`endif

  // An out-of-range index shifts the single set bit out of the vector, so the
  // one-hot value becomes zero. That zero can never match a mask bit.
  assign idx_onehot = NEURON_NUMBER'(1) << act_index;
  assign in_range   = {1'b0, act_index} < IDX_LIM;
  assign dup        = |(mask_q & idx_onehot);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    error_d = error_q;
    slots_d = slots_q;

    if (start) begin
      // start takes priority over any beat arriving on the same edge.
      state_d = COLLECT;
      mask_d  = '0;
      count_d = '0;
      error_d = 1'b0;
      slots_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        COLLECT: begin
          if (act_valid) begin
            if (!in_range || dup) begin
              error_d = 1'b1;
            end else begin
              mask_d  = mask_q | idx_onehot;
              count_d = count_q + CW'(1);
              for (int i = 0; i < NEURON_NUMBER; i++) begin
                if (idx_onehot[i]) slots_d[i*RESOLUTION +: RESOLUTION] = clip_val;
              end
              if (count_q == LAST_CNT) state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // The outputs are registered from the next-state value, so they line up with the state register.
    act_ready_d = (state_d == COLLECT);
    digit_en_d  = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      slots_q     <= '0;
      act_ready_q <= 1'b0;
      digit_en_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      error_q     <= error_d;
      slots_q     <= slots_d;
      act_ready_q <= act_ready_d;
      digit_en_q  <= digit_en_d;
      busy_q      <= busy_d;
    end
  end

  assign act_ready          = act_ready_q;
  assign digit_en           = digit_en_q;
  assign busy               = busy_q;
  assign error              = error_q;
  assign output_activations = slots_q;

endmodule

// File: tb/tb_activation_collector.sv
module tb_activation_collector;

  localparam int N = 10;
  localparam int R = 8;
  localparam int A = 16;

  logic           clk;
  logic           reset;
  logic           start;
  logic           act_valid;
  logic           act_ready;
  logic [3:0]     act_index;
  logic [A-1:0]   act_data;
  logic [R*N-1:0] output_activations;
  logic           digit_en;
  logic           busy;
  logic           error;

  activation_collector #(.NEURON_NUMBER(N), .RESOLUTION(R), .ACC_WIDTH(A)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .act_valid         (act_valid),
    .act_ready         (act_ready),
    .act_index         (act_index),
    .act_data          (act_data),
    .output_activations(output_activations),
    .digit_en          (digit_en),
    .busy              (busy),
    .error             (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a frame is a set of received indices plus slot values.
  bit        m_collect;
  bit        m_done;
  bit [15:0] m_mask;
  bit        m_err;
  int        m_slots[N];

  function automatic int clip(input int d);
`ifdef ACT_CLIP_EN
    if (d < 0) return 0;
    if (d > 255) return 255;
    return d;
`else
    return d & 255;
`endif
  endfunction

  task automatic model_clear();
    m_mask = '0;
    m_err  = 1'b0;
    for (int i = 0; i < N; i++) m_slots[i] = 0;
  endtask

  task automatic model_step(input bit v, input int idx, input int data, input bit st);
    if (st) begin
      m_collect = 1'b1;
      m_done    = 1'b0;
      model_clear();
    end else if (m_collect) begin
      if (v) begin
        if (idx >= N || m_mask[idx]) begin
          m_err = 1'b1;
        end else begin
          m_slots[idx] = clip(data);
          m_mask[idx]  = 1'b1;
          if ($countones(m_mask) == N) begin
            m_collect = 1'b0;
            m_done    = 1'b1;
          end
        end
      end
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [R*N-1:0] ev;
    for (int i = 0; i < N; i++) ev[i*R +: R] = 8'(m_slots[i]);
    check({tag, ".ready"}, 80'(act_ready), 80'(m_collect));
    check({tag, ".digit_en"}, 80'(digit_en), 80'(m_done));
    check({tag, ".busy"}, 80'(busy), 80'(m_collect | m_done));
    check({tag, ".error"}, 80'(error), 80'(m_err));
    check({tag, ".vec"}, 80'(output_activations), 80'(ev));
  endtask

  // One clock: drive the inputs, take the edge, advance the model, then compare.
  task automatic tick(input string tag, input bit v, input int idx, input int data, input bit st);
    act_valid = v;
    act_index = 4'(idx);
    act_data  = 16'(data);
    start     = st;
    @(posedge clk);
    #1;
    model_step(v, idx, data, st);
    act_valid = 1'b0;
    start     = 1'b0;
    check_all(tag);
  endtask

  function automatic int rnd_data();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; act_valid = 1'b0; act_index = '0; act_data = '0;
    m_collect = 1'b0; m_done = 1'b0; model_clear();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    tick("idle", 1'b1, 0, 5, 1'b0);

    // In-order frame.
    tick("io_start", 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < N; i++) tick("io_beat", 1'b1, i, 10 * i, 1'b0);
    check("io_digit_en", 80'(digit_en), 80'(1));
    check("io_slot9", 80'(output_activations[9*R +: R]), 80'(90));
    tick("io_after", 1'b0, 0, 0, 1'b0);
    check("io_busy_fall", 80'(busy), 80'(0));
    tick("io_idle", 1'b0, 0, 0, 1'b0);

    // Reverse order with gaps.
    tick("rv_start", 1'b0, 0, 0, 1'b1);
    for (int i = N - 1; i >= 0; i--) begin
      tick("rv_beat", 1'b1, i, 10 * i, 1'b0);
      if (i != 0) tick("rv_gap", 1'b0, 0, 0, 1'b0);
    end
    check("rv_digit_en", 80'(digit_en), 80'(1));
    tick("rv_after", 1'b0, 0, 0, 1'b0);

    // Clipping.
    tick("cl_start", 1'b0, 0, 0, 1'b1);
    tick("cl_neg", 1'b1, 0, -5, 1'b0);
    tick("cl_big", 1'b1, 1, 300, 1'b0);
    tick("cl_mid", 1'b1, 2, 200, 1'b0);
`ifdef ACT_CLIP_EN
    check("clip_s0", 80'(output_activations[0 +: R]), 80'(8'h00));
    check("clip_s1", 80'(output_activations[R +: R]), 80'(8'hFF));
`else
    check("clip_s0", 80'(output_activations[0 +: R]), 80'(8'hFB));
    check("clip_s1", 80'(output_activations[R +: R]), 80'(8'h2C));
`endif
    check("clip_s2", 80'(output_activations[2*R +: R]), 80'(8'hC8));
    for (int i = 3; i < N; i++) tick("cl_rand", 1'b1, i, rnd_data(), 1'b0);
    // start while DONE restarts collection at once.
    tick("cl_restart", 1'b0, 0, 0, 1'b1);

    // Duplicate and out-of-range indices.
    tick("du_first", 1'b1, 3, 7, 1'b0);
    tick("du_dup", 1'b1, 3, 99, 1'b0);
    check("dup_slot3", 80'(output_activations[3*R +: R]), 80'(7));
    check("dup_error", 80'(error), 80'(1));
    tick("du_oor", 1'b1, 12, 55, 1'b0);
    for (int i = 0; i < N; i++) if (i != 3) tick("du_fill", 1'b1, i, rnd_data(), 1'b0);
    check("du_digit_en", 80'(digit_en), 80'(1));
    tick("du_after", 1'b0, 0, 0, 1'b0);

    // Abort with start after 4 beats.
    tick("ab_start", 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) tick("ab_beat", 1'b1, i, rnd_data(), 1'b0);
    tick("ab_restart", 1'b0, 0, 0, 1'b1);
    check("ab_cleared", 80'(output_activations), 80'(0));
    // start coincident with a beat: the beat is dropped.
    tick("ab_coinc", 1'b1, 5, 77, 1'b1);
    check("coinc_slot5", 80'(output_activations[5*R +: R]), 80'(0));
    for (int i = 0; i < N; i++) tick("ab_full", 1'b1, i, rnd_data(), 1'b0);
    tick("ab_after", 1'b0, 0, 0, 1'b0);

    // Reset in the middle of a frame.
    tick("rs_start", 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 6; i++) tick("rs_beat", 1'b1, i, 100 + i, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    m_collect = 1'b0; m_done = 1'b0; model_clear();
    check_all("rs_async");
    @(posedge clk); #1;
    check_all("rs_held");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick("rs_idle", 1'b0, 0, 0, 1'b0);

    // Randomized traffic.
    tick("rnd_start", 1'b0, 0, 0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      tick("rnd", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 11)), rnd_data(),
           ($urandom_range(0, 99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
